// File: rtl/cv32e40p_x_result_tx.sv
// CORE-V-XIF result transmitter: in-order result FIFO gated by per-ID commit/kill bitmaps.
// Optional CV32E40P_X_RESULT_X0_FILTER_EN suppresses register writes to x0.
module cv32e40p_x_result_tx #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [ID_WIDTH-1:0]        res_id_i,
  input  logic [4:0]                 res_rd_i,
  input  logic [31:0]                res_data_i,
  input  logic                       res_we_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       x_result_valid_o,
  input  logic                       x_result_ready_i,
  output logic [ID_WIDTH-1:0]        x_result_id_o,
  output logic [4:0]                 x_result_rd_o,
  output logic [31:0]                x_result_data_o,
  output logic                       x_result_we_o,
  output logic [$clog2(DEPTH):0]     fifo_cnt_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int NID = 2 ** ID_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ID_WIDTH-1:0] mem_id   [DEPTH];
  logic [4:0]          mem_rd   [DEPTH];
  logic [31:0]         mem_data [DEPTH];
  logic                mem_we   [DEPTH];

  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       cnt;
  logic [NID-1:0]      committed, killed;
  logic [NID-1:0]      committed_nxt, killed_nxt;
  logic [ID_WIDTH-1:0] head_id;
  logic                empty, push, push_drop, push_store;
  logic                head_killed, pop, advance;

  assign head_id     = mem_id[rd_ptr];
  assign empty       = (cnt == '0);
  assign res_ready_o = (cnt != FULL_CNT);

  // A result whose kill was already seen is acknowledged but never stored.
  assign push        = res_valid_i & res_ready_o;
  assign push_drop   = push & killed[res_id_i];
  assign push_store  = push & ~killed[res_id_i];

  assign head_killed      = ~empty & killed[head_id];
  assign x_result_valid_o = ~empty & committed[head_id] & ~killed[head_id];
  assign pop              = x_result_valid_o & x_result_ready_i;
  assign advance          = pop | head_killed;

  always_comb begin
    committed_nxt = committed;
    killed_nxt    = killed;
    if (pop)         committed_nxt[head_id] = 1'b0;
    if (head_killed) killed_nxt[head_id]    = 1'b0;
    if (push_drop)   killed_nxt[res_id_i]   = 1'b0;
    if (commit_valid_i) begin
      if (!commit_kill_i)
        committed_nxt[commit_id_i] = 1'b1;
      else if (!committed[commit_id_i])
        killed_nxt[commit_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      committed <= '0;
      killed    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_id[i]   <= '0;
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
        mem_we[i]   <= 1'b0;
      end
    end else begin
      committed <= committed_nxt;
      killed    <= killed_nxt;
      cnt       <= cnt + CW'(push_store) - CW'(advance);
      if (push_store) begin
        mem_id[wr_ptr]   <= res_id_i;
        mem_rd[wr_ptr]   <= res_rd_i;
        mem_data[wr_ptr] <= res_data_i;
        mem_we[wr_ptr]   <= res_we_i;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (advance) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign x_result_id_o   = mem_id[rd_ptr];
  assign x_result_rd_o   = mem_rd[rd_ptr];
  assign x_result_data_o = mem_data[rd_ptr];
  assign fifo_cnt_o      = cnt;

`ifdef CV32E40P_X_RESULT_X0_FILTER_EN
  assign x_result_we_o = mem_we[rd_ptr] & (mem_rd[rd_ptr] != 5'd0);
`else
  assign x_result_we_o = mem_we[rd_ptr];
`endif

endmodule
